dmux4way16_reg: RTL
===================

Name: dmux4way16_reg

Overview:
- Registered 4-way 16-bit demultiplexer: the distributing counterpart of the 4-way 16-bit selector.
- Accepts one 16-bit word per handshake and steers it, by 2-bit sel, into one of four output channels.
- Each output channel holds its word in a 1-entry holding register until the consumer takes it.
- Sits between the datapath and four independent consumers, e.g. register-bank write ports or per-unit operand latches.

Parameters:
- WIDTH, 16, data width of input and of each output channel.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  data word to route.
- sel  input  2  destination channel (0..3); qualified only while in_valid=1.
- in_valid  input  1  producer offers in/sel this cycle.
- in_ready  output  1  block accepts in/sel this cycle (combinational).
- out0, out1, out2, out3  output  WIDTH  channel holding-register contents.
- out_valid  output  4  bit i = channel i holds an undelivered word.
- out_ready  input  4  bit i = consumer i takes channel i's word this cycle.

Behaviour:
- Sampling: all state changes on rising clk; reset sampled synchronously and wins over every other event.
- Reset values: out0..out3 = 0, out_valid = 4'b0000. in_ready follows its equation, so it is 1 after reset.
- Handshakes:
  - accept = in_valid & in_ready.
  - drain_i = out_valid[i] & out_ready[i].
- in_ready = ~out_valid[sel] | out_ready[sel]. This is a combinational path from sel and out_ready; channel sel may be refilled in the cycle it drains.
- On accept:
  - reg[sel] <= in and out_valid[sel] <= 1 at the next edge.
  - Latency is 1 cycle from accept to the word visible with out_valid.
- On drain_i with no accept to channel i: out_valid[i] <= 0. outi keeps its last value; it is never cleared to 0 except by reset.
- Drain and accept on the same channel in the same cycle: the old word is delivered, the new word is loaded, and out_valid[i] stays 1. There is no bubble.
- Non-selected channels are unaffected by in/sel/in_valid; their drains proceed independently and in parallel.
- Multiple channels may drain in the same cycle; only one channel can be loaded per cycle.
- in_valid=1 with in_ready=0:
  - No state change.
  - The producer must hold in/sel stable until accept; the block does not check this.
- in_valid=0: sel and in are don't-care, no load.
- in_ready may be 1 while in_valid=0; this has no effect.
- Full condition: all four out_valid=1 with out_ready=0 gives in_ready=0 for every sel value.
- Reset mid-operation: pending words are discarded and out_valid clears at that edge. An accept or drain in the same cycle as reset is ignored. The consumer must treat reset as a flush.
- X-safety: out_valid never goes X after reset, whatever in/sel do while in_valid=0.

Decomposition:
- Shared package dmux_pkg:
  - NUM_CH = 4.
  - SEL_W = 2.
  - Default WIDTH = 16.
  - Channel-index constants CH0..CH3.
- Sub-module dmux_chan_reg, instantiated 4 times:
  - Inputs: clk, reset, load, din[WIDTH], drain.
  - Outputs: dout[WIDTH], valid.
  - Implements the load/drain/hold rules for one channel.
- Top level computes:
  - the 1-hot load vector from sel & accept;
  - the in_ready mux over the per-channel (~valid | out_ready) terms.

Test Plan:
- Reset release: reset=1 for 2 cycles, then 0 → out_valid=0000, out0..3=0000h, in_ready=1.
- Single route: in=ABCDh, sel=2, in_valid=1 for 1 cycle, out_ready=0000 → next cycle out2=ABCDh, out_valid=0100; other outputs 0.
- Backpressure: channel 1 full, out_ready[1]=0, sel=1, in_valid=1 → in_ready=0; out1 keeps old value 1111h. Raise out_ready[1] in the same cycle → in_ready=1, and out1=2222h next cycle with out_valid[1] still 1.
- All full: load 0001h, 0002h, 0003h, 0004h to ch 0..3 in 4 consecutive cycles → out_valid=1111, in_ready=0 for each of sel=0..3. Then out_ready=1111 for 1 cycle → out_valid=0000 and out0..3 hold 0001h..0004h.
- Parallel drain and load: ch0 and ch3 full, out_ready=1001, load sel=2 with 5A5Ah in the same cycle → next cycle out_valid=0100, out2=5A5Ah.
- Reset mid-operation: out_valid=1011, assert reset together with an accept (sel=2, in=FFFFh) → next cycle out_valid=0000 and out0..3=0000h.

Source files
------------

// File: rtl/dmux_pkg.sv
// -----------------------------------------------------------------------------
// dmux_pkg
//
// Purpose : Shared constants and helpers for the registered 4-way
//           demultiplexer (dmux4way16_reg) and its per-channel holding
//           register (dmux_chan_reg).
//
// Contents:
//   NUM_CH        number of output channels
//   SEL_W         width of the channel-select field
//   DEFAULT_WIDTH default data width of input and each channel
//   sel_t         channel-select type
//   CH0..CH3      channel-index constants
//   sel_onehot()  decode a channel index into a one-hot channel vector
// -----------------------------------------------------------------------------
package dmux_pkg;

    localparam int NUM_CH        = 4;
    localparam int SEL_W         = 2;
    localparam int DEFAULT_WIDTH = 16;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t CH0 = 2'd0;
    localparam sel_t CH1 = 2'd1;
    localparam sel_t CH2 = 2'd2;
    localparam sel_t CH3 = 2'd3;

    // One-hot decode of a channel index. The caller gates the result with
    // the accept strobe so that an unqualified sel never produces a load.
    function automatic logic [NUM_CH-1:0] sel_onehot(input sel_t s);
        logic [NUM_CH-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage : dmux_pkg

// File: rtl/dmux_chan_reg.sv
// -----------------------------------------------------------------------------
// dmux_chan_reg
//
// Purpose : One-entry holding register for a single output channel of the
//           demultiplexer. Holds a word from the cycle after it is loaded
//           until the consumer takes it.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset; clears data and valid
//   load   in   write din into the register this cycle (accept to this channel)
//   din    in   WIDTH data word to load
//   drain  in   consumer takes the held word this cycle (valid & ready)
//   dout   out  WIDTH held word; keeps its last value after being drained
//   valid  out  register holds an undelivered word
// -----------------------------------------------------------------------------
module dmux_chan_reg
    import dmux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             drain,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    // Data register: only a load or reset changes it. A drain leaves the
    // last word visible, so consumers that sample late still see stable data.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end
    end

    // Valid flag: load takes priority over drain so that a same-cycle drain
    // and refill delivers the old word and keeps the channel full with the
    // new one, with no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule : dmux_chan_reg

// File: rtl/dmux4way16_reg.sv
// -----------------------------------------------------------------------------
// dmux4way16_reg
//
// Purpose : Registered 4-way demultiplexer. Accepts one word per input
//           handshake and steers it, by sel, into one of four one-entry
//           output holding registers, each drained by its own consumer.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset (flushes all channels)
//   in         in   WIDTH data word to route
//   sel        in   destination channel 0..3, qualified by in_valid
//   in_valid   in   producer offers in/sel this cycle
//   in_ready   out  block accepts in/sel this cycle (combinational)
//   out0..out3 out  WIDTH channel holding-register contents
//   out_valid  out  bit i: channel i holds an undelivered word
//   out_ready  in   bit i: consumer i takes channel i's word this cycle
//
// Handshake semantics (input and every output channel):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   in_ready depends combinationally on sel and out_ready, so the producer
//   must not make in_valid depend on in_ready. While in_valid=1 and
//   in_ready=0 the producer holds in/sel stable; this is not checked here.
//   Each out_valid[i] stays high, with outi stable, until out_ready[i]
//   completes the transfer. Reset discards any pending words.
// -----------------------------------------------------------------------------
module dmux4way16_reg
    import dmux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready
);

    logic [NUM_CH-1:0] ch_free;   // channel can take a word this cycle
    logic [NUM_CH-1:0] ch_load;   // one-hot load strobe
    logic [NUM_CH-1:0] ch_drain;  // per-channel output transfer
    logic              accept;
    logic [WIDTH-1:0]  ch_data [NUM_CH];

    // A channel is free when it is empty or is being drained this cycle,
    // which lets a channel be refilled in the same cycle it empties.
    assign ch_free  = ~out_valid | out_ready;
    assign in_ready = ch_free[sel];

    // in_valid gates everything derived from sel/in, so unknown values on
    // those inputs while idle cannot reach the channel state.
    assign accept   = in_valid & in_ready;
    assign ch_load  = sel_onehot(sel) & {NUM_CH{accept}};
    assign ch_drain = out_valid & out_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        dmux_chan_reg #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .load  (ch_load[i]),
            .din   (in),
            .drain (ch_drain[i]),
            .dout  (ch_data[i]),
            .valid (out_valid[i])
        );
    end

    assign out0 = ch_data[CH0];
    assign out1 = ch_data[CH1];
    assign out2 = ch_data[CH2];
    assign out3 = ch_data[CH3];

endmodule : dmux4way16_reg
